// File: rtl/button_conditioner.sv
// Turns four bouncy active-low push-buttons into single-cycle move commands,
// with near-simultaneous presses queued by priority and hold-to-repeat.
//
// state  | meaning
// IDLE   | no auto-repeat armed
// DELAY  | one button held since its command, waiting for the first repeat
// REPEAT | same button still held, repeating every REPEAT_RATE cycles
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rawBtn,
    output logic [3:0] btnCode,
    output logic       btnValid
);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

    localparam logic [CNT_W-1:0] DB_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_TC = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_TC = CNT_W'(REPEAT_RATE - 1);

    logic [3:0]       sync1_q, sync2_q;
    logic [1:0]       fill_q, fill_d;
    logic [3:0]       block_q, block_d;
    logic [CNT_W-1:0] db_cnt_q [4];
    logic [CNT_W-1:0] db_cnt_d [4];
    logic [3:0]       deb_q, deb_d;
    logic [3:0]       pend_q, pend_d;
    logic [3:0]       rec_q, rec_d;
    rep_state_t       state_q, state_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d, rep_tc;
    logic [3:0]       code_q, code_d;
    logic             valid_q;
    logic [3:0]       pressed, target, rise, sel, rep_set;
    logic             one_hot;

    assign pressed = ~sync2_q;
    assign fill_d  = {fill_q[0], 1'b1};
    // A button already down when reset releases stays masked until it is seen released.
    assign block_d = block_q & ~({4{fill_q[1]}} & ~pressed);
    assign target  = pressed & ~block_q;

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (target[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_TC) deb_d[i] = target[i];
                else                      db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign rise    = deb_d & ~deb_q;
    assign one_hot = (deb_q != 4'b0000) && ((deb_q & (deb_q - 4'd1)) == 4'b0000);

    always_comb begin
        sel = 4'b0000;
        if      (pend_q[3]) sel = 4'b1000;
        else if (pend_q[2]) sel = 4'b0100;
        else if (pend_q[1]) sel = 4'b0010;
        else if (pend_q[0]) sel = 4'b0001;
    end

    assign code_d = ~sel;

    // The repeat interval is timed from the cycle the previous command leaves,
    // so the counter is held at zero while the recorded button is still pending.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        rec_d     = rec_q;
        rep_set   = 4'b0000;
        rep_tc    = (state_q == DELAY) ? DLY_TC : RPT_TC;
        case (state_q)
            IDLE: begin
                rep_cnt_d = '0;
                if ((sel != 4'b0000) && one_hot) begin
                    state_d = DELAY;
                    rec_d   = deb_q;
                end
            end
            default: begin
                if (deb_q != rec_q) begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end else if ((pend_q & rec_q) != 4'b0000) begin
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == rep_tc) begin
                    rep_set   = rec_q;
                    rep_cnt_d = '0;
                    state_d   = REPEAT;
                end else begin
                    rep_cnt_d = rep_cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign pend_d = (pend_q & ~sel) | rise | rep_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 4'hF;
            sync2_q   <= 4'hF;
            fill_q    <= 2'b00;
            block_q   <= 4'hF;
            deb_q     <= 4'h0;
            pend_q    <= 4'h0;
            rec_q     <= 4'h0;
            state_q   <= IDLE;
            rep_cnt_q <= '0;
            code_q    <= 4'hF;
            valid_q   <= 1'b0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q   <= rawBtn;
            sync2_q   <= sync1_q;
            fill_q    <= fill_d;
            block_q   <= block_d;
            deb_q     <= deb_d;
            pend_q    <= pend_d;
            rec_q     <= rec_d;
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
            code_q    <= code_d;
            valid_q   <= ~&code_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    assign btnCode  = code_q;
    assign btnValid = valid_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short debounce/repeat timings; expected
// per-cycle outputs are queued as stimulus is driven and checked mid-cycle.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rawBtn;
    logic [3:0] btnCode;
    logic       btnValid;
    logic       done = 1'b0;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .CNT_W          (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rawBtn  (rawBtn),
        .btnCode (btnCode),
        .btnValid(btnValid)
    );

    typedef struct {
        string            name;
        logic [3:0]       raw0;
        int               chg_at;
        logic [3:0]       raw1;
        int               rel_at;
        int               ncyc;
        int               n;
        logic [5:0][7:0]  at;
        logic [5:0][3:0]  code;
    } vec_t;

    vec_t       vecs [6];
    logic [3:0] exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    string      cur   = "init";

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            n_vec++;
            if (btnCode !== e || btnValid !== (e != 4'hF)) begin
                n_err++;
                $display("FAIL %s cycle %0d: btnCode=%b btnValid=%b, expected btnCode=%b btnValid=%b",
                         cur, cyc, btnCode, btnValid, e, (e != 4'hF));
            end
        end
    end

    initial begin
        #200000;
        if (!done) begin
            n_err++;
            $display("FAIL timeout: stimulus did not complete in time (%s cycle %0d)", cur, cyc);
            $finish;
        end
    end

    task automatic step(input logic [3:0] raw, input logic rst, input logic [3:0] e, input int t);
        rawBtn = raw;
        reset  = rst;
        cyc    = t;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int k, input string nm, input logic [3:0] r0, input int chg,
                           input logic [3:0] r1, input int rel, input int nc);
        vecs[k].name   = nm;
        vecs[k].raw0   = r0;
        vecs[k].chg_at = chg;
        vecs[k].raw1   = r1;
        vecs[k].rel_at = rel;
        vecs[k].ncyc   = nc;
        vecs[k].n      = 0;
        vecs[k].at     = '0;
        vecs[k].code   = '0;
    endtask

    task automatic add_cmd(input int k, input int t, input logic [3:0] c);
        vecs[k].at[vecs[k].n]   = 8'(t);
        vecs[k].code[vecs[k].n] = c;
        vecs[k].n++;
    endtask

    function automatic logic [3:0] exp_at(input int k, input int t);
        logic [3:0] e = 4'hF;
        for (int j = 0; j < vecs[k].n; j++)
            if (int'(vecs[k].at[j]) == t) e = vecs[k].code[j];
        return e;
    endfunction

    function automatic logic [3:0] raw_at(input int k, input int t);
        if (t >= vecs[k].rel_at) return 4'hF;
        if (t >= vecs[k].chg_at) return vecs[k].raw1;
        return vecs[k].raw0;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'hF, 1'b0, 4'hF, -1);
    endtask

    initial begin
        reset  = 1'b1;
        rawBtn = 4'hF;
        @(posedge clk);
        #1;
        cur = "reset_state";
        step(4'hF, 1'b1, 4'hF, 0);
        n_vec++;
        if (btnCode !== 4'hF || btnValid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: btnCode=%b btnValid=%b after reset, expected 1111/0",
                     btnCode, btnValid);
        end
        step(4'hF, 1'b0, 4'hF, 1);
        idle(8);

        set_vec(0, "bounce_3cyc", 4'b0111, 999, 4'hF, 3, 20);
        set_vec(1, "min_press_4cyc", 4'b0111, 999, 4'hF, 4, 20);
        add_cmd(1, 7, 4'b0111);
        set_vec(2, "down_press", 4'b1101, 999, 4'hF, 10, 25);
        add_cmd(2, 7, 4'b1101);
        set_vec(3, "left_right", 4'b1010, 999, 4'hF, 40, 55);
        add_cmd(3, 7, 4'b1011);
        add_cmd(3, 8, 4'b1110);
        set_vec(4, "right_repeat", 4'b1110, 999, 4'hF, 56, 80);
        add_cmd(4, 7, 4'b1110);
        add_cmd(4, 28, 4'b1110);
        add_cmd(4, 37, 4'b1110);
        add_cmd(4, 46, 4'b1110);
        add_cmd(4, 55, 4'b1110);
        set_vec(5, "up_then_down", 4'b0111, 15, 4'b0101, 40, 60);
        add_cmd(5, 7, 4'b0111);
        add_cmd(5, 22, 4'b1101);

        for (int k = 0; k < 6; k++) begin
            cur = vecs[k].name;
            for (int t = 0; t < vecs[k].ncyc; t++)
                step(raw_at(k, t), 1'b0, exp_at(k, t), t);
            idle(8);
        end

        // A glitch back to released mid-count restarts the debounce count.
        cur = "glitch_restart";
        for (int t = 0; t < 30; t++)
            step(((t < 3) || (t >= 4 && t < 9)) ? 4'b0111 : 4'hF, 1'b0,
                 (t == 11) ? 4'b0111 : 4'hF, t);
        idle(8);

        // Reset pulse while held: no command until released and pressed again.
        cur = "reset_while_held";
        for (int t = 0; t < 70; t++)
            step(((t < 30) || (t >= 40 && t < 50)) ? 4'b1011 : 4'hF, (t == 12),
                 (t == 7 || t == 47) ? 4'b1011 : 4'hF, t);
        idle(4);

        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected values never checked", exp_q.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
